fgh_add_arbiter: RTL and testbench
==================================

FGH_ADD_ARBITER -- requirements
Module: fgh_add_arbiter

Interface
REQ-001 The block SHALL have no parameters; the requester count is fixed at 3 and the data width at 4 bits.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: clr  input  1  synchronous clear of f, g and h.
REQ-005 Port: req_valid  input  3  request from requester i (bit 0 targets f, bit 1 targets g, bit 2 targets h).
REQ-006 Port: req_data  input  12  4-bit operand per requester; bits [4i+3:4i] belong to requester i.
REQ-007 Port: req_ready  output  3  grant strobe; at most one bit high per cycle.
REQ-008 Port: done  output  3  one-cycle pulse when requester i's result is written.
REQ-009 Port: f, g, h  output  4 each  accumulator registers.
REQ-010 Port: busy  output  1  high while the execute stage holds a valid operation.

Function
REQ-011 The block SHALL share one 4-bit adder among three requesters; requester i adds its operand into its own register (0->f, 1->g, 2->h).
REQ-012 Handshake: a transfer on requester i SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high; req_ready SHALL be combinational from req_valid, the round-robin pointer and clr.
REQ-013 Arbitration SHALL be round-robin: a 2-bit pointer (values 0..2) gives the highest-priority index; the search order is ptr, ptr+1, ptr+2, modulo 3.
REQ-014 After each transfer the pointer SHALL become (winner+1) mod 3; with no transfer the pointer SHALL hold.
REQ-015 Pipeline: the accepted operand and index SHALL register into an execute stage at the accept edge; the target register SHALL update, and done[i] SHALL pulse, on the following edge (latency 1 cycle after accept).
REQ-016 One transfer per cycle SHALL be sustainable back-to-back with no bubble.
REQ-017 Arithmetic SHALL wrap modulo 16 (e.g. 0xE + 0x3 = 0x1) unless ADD_SAT_EN is defined.
REQ-018 busy SHALL equal the execute-stage valid bit.
REQ-019 clr high SHALL force req_ready to 3'b000 in that cycle.
REQ-020 At the edge where clr is sampled, f, g and h SHALL become 0, any in-flight execute-stage operation SHALL be discarded with no done pulse, and the pointer SHALL be kept.
REQ-021 With req_valid = 0, req_ready SHALL be 0, no state SHALL change, and f, g and h SHALL hold.
REQ-022 req_data on a non-granted requester SHALL be ignored.

Reset
REQ-023 While reset is low, asynchronously: f = g = h = 0, pointer = 0, execute-stage valid = 0, done = 0, busy = 0.
REQ-024 req_ready SHALL be 0 while reset is low.
REQ-025 An operation accepted or in flight when reset asserts SHALL be lost; no done pulse SHALL follow.
REQ-026 Normal operation SHALL resume on the first rising edge of clk after reset deasserts.

Configuration
REQ-027 Macro ADD_SAT_EN defined: the addition SHALL saturate at 4'hF (e.g. 0xE + 0x3 = 0xF).
REQ-028 Macro ADD_SAT_EN undefined: the addition SHALL wrap per REQ-017.
REQ-029 The port list and timing SHALL be identical in both configurations.

Verification
REQ-030 Reset check: hold reset low for 5 time units with valid = 3'b111 -> f, g, h = 0, req_ready = 0, busy = 0 throughout.
REQ-031 Single request: req_valid = 3'b001, data 0x5, for one cycle -> ready[0] high in that cycle, done[0] and f = 5 one cycle later, busy high for exactly 1 cycle.
REQ-032 Round robin: all three valid for 6 cycles, data 1 each -> grant order 0, 1, 2, 0, 1, 2; finally f = g = h = 2.
REQ-033 Wrap: g = 0xE, then add 0x3 -> g = 0x1; with ADD_SAT_EN defined -> g = 0xF.
REQ-034 Clear collision: assert clr in the cycle after an accept into h -> no done[2], h = 0, no ready in the clr cycle, pointer unchanged.
REQ-035 Mid-operation reset: assert reset while busy = 1 -> done stays 0, all outputs 0; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/fgh_add_arbiter.sv
// Three requesters share one 4-bit adder through a round-robin arbiter; requester i accumulates into f/g/h.
// Define ADD_SAT_EN to saturate the sum at 4'hF instead of wrapping modulo 16.
module fgh_add_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic [2:0]  req_valid,
    input  logic [11:0] req_data,
    output logic [2:0]  req_ready,
    output logic [2:0]  done,
    output logic [3:0]  f,
    output logic [3:0]  g,
    output logic [3:0]  h,
    output logic        busy
);

    logic [1:0] ptr_q, ptr_d;
    logic       ex_vld_q, ex_vld_d;
    logic [1:0] ex_idx_q, ex_idx_d;
    logic [3:0] ex_data_q, ex_data_d;
    logic [3:0] f_q, f_d, g_q, g_d, h_q, h_d;
    logic [2:0] done_q, done_d;

    logic       gnt_vld;
    logic [1:0] gnt_idx;
    logic [1:0] cand;
    logic [3:0] gnt_data;
    logic       accept;
    logic [3:0] acc;
    logic [3:0] add_res;

    // Scan from lowest to highest priority so the last hit (offset 0 = ptr) wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            cand = 2'((int'(ptr_q) + k) % 3);
            if (req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign accept    = gnt_vld & ~clr;
    assign req_ready = (reset && accept) ? 3'(3'b001 << gnt_idx) : 3'b000;
    assign gnt_data  = req_data[{gnt_idx, 2'b00} +: 4];

    always_comb begin
        case (ex_idx_q)
            2'd0:    acc = f_q;
            2'd1:    acc = g_q;
            default: acc = h_q;
        endcase
    end

`ifdef ADD_SAT_EN
    logic [4:0] sum;
    assign sum     = {1'b0, acc} + {1'b0, ex_data_q};
    assign add_res = sum[4] ? 4'hF : sum[3:0];
`else
    assign add_res = acc + ex_data_q;
`endif

    always_comb begin
        f_d       = f_q;
        g_d       = g_q;
        h_d       = h_q;
        ptr_d     = ptr_q;
        ex_vld_d  = 1'b0;
        ex_idx_d  = ex_idx_q;
        ex_data_d = ex_data_q;
        done_d    = 3'b000;
        if (clr) begin
            // In-flight op is dropped silently; the pointer is deliberately kept.
            f_d = 4'h0;
            g_d = 4'h0;
            h_d = 4'h0;
        end else begin
            if (ex_vld_q) begin
                case (ex_idx_q)
                    2'd0: begin f_d = add_res; done_d = 3'b001; end
                    2'd1: begin g_d = add_res; done_d = 3'b010; end
                    2'd2: begin h_d = add_res; done_d = 3'b100; end
                    default: ;
                endcase
            end
            if (accept) begin
                ex_vld_d  = 1'b1;
                ex_idx_d  = gnt_idx;
                ex_data_d = gnt_data;
                ptr_d     = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q     <= 2'd0;
            ex_vld_q  <= 1'b0;
            ex_idx_q  <= 2'd0;
            ex_data_q <= 4'h0;
            f_q       <= 4'h0;
            g_q       <= 4'h0;
            h_q       <= 4'h0;
            done_q    <= 3'b000;
        end else begin
            ptr_q     <= ptr_d;
            ex_vld_q  <= ex_vld_d;
            ex_idx_q  <= ex_idx_d;
            ex_data_q <= ex_data_d;
            f_q       <= f_d;
            g_q       <= g_d;
            h_q       <= h_d;
            done_q    <= done_d;
        end
    end

    assign done = done_q;
    assign f    = f_q;
    assign g    = g_q;
    assign h    = h_q;
    assign busy = ex_vld_q;

endmodule

// File: tb/tb_fgh_add_arbiter.sv
// Directed bench for fgh_add_arbiter: vector table plus hand-written clear and reset sequences.
module tb_fgh_add_arbiter;

    logic        clk;
    logic        reset;
    logic        clr;
    logic [2:0]  req_valid;
    logic [11:0] req_data;
    logic [2:0]  req_ready;
    logic [2:0]  done;
    logic [3:0]  f, g, h;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef ADD_SAT_EN
    localparam logic [3:0] G_WR = 4'hF;
`else
    localparam logic [3:0] G_WR = 4'h1;
`endif

    typedef struct {
        logic [2:0]  v;
        logic [11:0] d;
        logic        c;
        logic [2:0]  rdy;
        logic [2:0]  dn;
        logic [3:0]  ef;
        logic [3:0]  eg;
        logic [3:0]  eh;
        logic        bz;
    } vec_t;

    vec_t tbl[17];

    fgh_add_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .done      (done),
        .f         (f),
        .g         (g),
        .h         (h),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [2:0] v, input logic [11:0] d, input logic c);
        @(negedge clk);
        req_valid = v;
        req_data  = d;
        clr       = c;
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " f"},     16'(f),         16'h0);
        chk({tag, " g"},     16'(g),         16'h0);
        chk({tag, " h"},     16'(h),         16'h0);
        chk({tag, " ready"}, 16'(req_ready), 16'h0);
        chk({tag, " busy"},  16'(busy),      16'h0);
        chk({tag, " done"},  16'(done),      16'h0);
    endtask

    initial begin
        //          valid   data     clr   ready   done    f     g     h     busy
        tbl[0]  = '{3'b001, 12'h005, 1'b0, 3'b001, 3'b000, 4'h0, 4'h0, 4'h0, 1'b0};
        tbl[1]  = '{3'b000, 12'h000, 1'b0, 3'b000, 3'b000, 4'h0, 4'h0, 4'h0, 1'b1};
        tbl[2]  = '{3'b000, 12'h000, 1'b0, 3'b000, 3'b001, 4'h5, 4'h0, 4'h0, 1'b0};
        tbl[3]  = '{3'b000, 12'h000, 1'b0, 3'b000, 3'b000, 4'h5, 4'h0, 4'h0, 1'b0};
        tbl[4]  = '{3'b111, 12'h111, 1'b0, 3'b010, 3'b000, 4'h5, 4'h0, 4'h0, 1'b0};
        tbl[5]  = '{3'b111, 12'h111, 1'b0, 3'b100, 3'b000, 4'h5, 4'h0, 4'h0, 1'b1};
        tbl[6]  = '{3'b111, 12'h111, 1'b0, 3'b001, 3'b010, 4'h5, 4'h1, 4'h0, 1'b1};
        tbl[7]  = '{3'b111, 12'h111, 1'b0, 3'b010, 3'b100, 4'h5, 4'h1, 4'h1, 1'b1};
        tbl[8]  = '{3'b111, 12'h111, 1'b0, 3'b100, 3'b001, 4'h6, 4'h1, 4'h1, 1'b1};
        tbl[9]  = '{3'b111, 12'h111, 1'b0, 3'b001, 3'b010, 4'h6, 4'h2, 4'h1, 1'b1};
        tbl[10] = '{3'b000, 12'h000, 1'b0, 3'b000, 3'b100, 4'h6, 4'h2, 4'h2, 1'b1};
        tbl[11] = '{3'b000, 12'h000, 1'b0, 3'b000, 3'b001, 4'h7, 4'h2, 4'h2, 1'b0};
        tbl[12] = '{3'b010, 12'hFCF, 1'b0, 3'b010, 3'b000, 4'h7, 4'h2, 4'h2, 1'b0};
        tbl[13] = '{3'b010, 12'hA3A, 1'b0, 3'b010, 3'b000, 4'h7, 4'h2, 4'h2, 1'b1};
        tbl[14] = '{3'b000, 12'h000, 1'b0, 3'b000, 3'b010, 4'h7, 4'hE, 4'h2, 1'b1};
        tbl[15] = '{3'b000, 12'h000, 1'b0, 3'b000, 3'b010, 4'h7, G_WR, 4'h2, 1'b0};
        tbl[16] = '{3'b000, 12'h000, 1'b0, 3'b000, 3'b000, 4'h7, G_WR, 4'h2, 1'b0};

        // Reset held low with all requesters active
        reset     = 1'b0;
        clr       = 1'b0;
        req_valid = 3'b111;
        req_data  = 12'h555;
        #1;
        chk_zero("rst t1");
        @(negedge clk); #2;
        chk_zero("rst t12");
        @(negedge clk); #2;
        chk_zero("rst t22");
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 3'b000;
        req_data  = 12'h000;

        for (int i = 0; i < 17; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].c);
            chk($sformatf("row%0d ready", i), 16'(req_ready), 16'(tbl[i].rdy));
            chk($sformatf("row%0d done", i),  16'(done),      16'(tbl[i].dn));
            chk($sformatf("row%0d f", i),     16'(f),         16'(tbl[i].ef));
            chk($sformatf("row%0d g", i),     16'(g),         16'(tbl[i].eg));
            chk($sformatf("row%0d h", i),     16'(h),         16'(tbl[i].eh));
            chk($sformatf("row%0d busy", i),  16'(busy),      16'(tbl[i].bz));
        end

        // Clear in the cycle after an accept into h
        cyc(3'b100, 12'h500, 1'b0);
        chk("clr acc ready", 16'(req_ready), 16'h4);
        cyc(3'b111, 12'h999, 1'b1);
        chk("clr cyc ready", 16'(req_ready), 16'h0);
        chk("clr cyc busy",  16'(busy),      16'h1);
        cyc(3'b000, 12'h000, 1'b0);
        chk("clr post done", 16'(done), 16'h0);
        chk("clr post h",    16'(h),    16'h0);
        chk("clr post f",    16'(f),    16'h0);
        chk("clr post g",    16'(g),    16'h0);
        chk("clr post busy", 16'(busy), 16'h0);
        // Clear with a nonzero pointer: pointer must survive
        cyc(3'b001, 12'h001, 1'b0);
        chk("clr2 acc ready", 16'(req_ready), 16'h1);
        chk("clr2 acc done",  16'(done),      16'h0);
        cyc(3'b111, 12'h111, 1'b1);
        chk("clr2 cyc ready", 16'(req_ready), 16'h0);
        cyc(3'b111, 12'h111, 1'b0);
        chk("clr2 ptr kept ready", 16'(req_ready), 16'h2);
        chk("clr2 done",           16'(done),      16'h0);
        chk("clr2 f",              16'(f),         16'h0);
        chk("clr2 busy",           16'(busy),      16'h0);

        // Reset while an operation is in the execute stage
        cyc(3'b000, 12'h000, 1'b0);
        chk("mrst pre busy", 16'(busy), 16'h1);
        reset     = 1'b0;
        req_valid = 3'b111;
        req_data  = 12'h111;
        #1;
        chk_zero("mrst low");
        @(negedge clk);
        #1;
        chk_zero("mrst held");
        reset     = 1'b1;
        req_valid = 3'b000;
        cyc(3'b000, 12'h000, 1'b0);
        chk("mrst post done", 16'(done), 16'h0);
        chk("mrst post g",    16'(g),    16'h0);
        chk("mrst post busy", 16'(busy), 16'h0);

        // Round robin from a fresh pointer
        for (int k = 0; k < 6; k++) begin
            cyc(3'b111, 12'h111, 1'b0);
            chk($sformatf("rr grant%0d", k), 16'(req_ready), 16'(3'b001 << (k % 3)));
        end
        cyc(3'b000, 12'h000, 1'b0);
        cyc(3'b000, 12'h000, 1'b0);
        chk("rr f",    16'(f),    16'h2);
        chk("rr g",    16'(g),    16'h2);
        chk("rr h",    16'(h),    16'h2);
        chk("rr busy", 16'(busy), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
